// File: rtl/fetch_stage_pkg.sv
// Shared fetch pipeline definitions: FSM encoding, buffer depth, control opcodes.
// Pure declarations, no timing or flow-control behaviour of its own.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_t;

  localparam int FETCH_DEPTH = 2;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic is_ctrl_op(input logic [31:0] word);
    return (word[6:0] == OPC_JAL) || (word[6:0] == OPC_JALR) || (word[6:0] == OPC_BRANCH);
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry {pc, inst} FIFO, head visible combinationally; push+pop allowed even when full.
// Push is refused only when full without a pop; flush empties it in one cycle (FETCH_PREDECODE_EN adds a ctrl bit).
module fetch_buffer
  import fetch_stage_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_dat,
`ifdef FETCH_PREDECODE_EN
  input  logic         push_ctrl,
  output logic         head_ctrl,
`endif
  input  logic         pop,
  output logic         head_vld,
  output fetch_entry_t head_dat,
  output logic         full
);

  fetch_entry_t mem [FETCH_DEPTH];
`ifdef FETCH_PREDECODE_EN
  logic [FETCH_DEPTH-1:0] ctrl_mem;
`endif
  logic       rd_ptr;
  logic       wr_ptr;
  logic [1:0] occ;
  logic       do_push;
  logic       do_pop;

  assign full     = (occ == 2'(FETCH_DEPTH));
  assign head_vld = (occ != 2'd0);
  assign head_dat = mem[rd_ptr];
`ifdef FETCH_PREDECODE_EN
  assign head_ctrl = ctrl_mem[rd_ptr];
`endif

  // An empty pop is a no-op; a full push only lands when the head leaves in the same cycle.
  assign do_pop  = pop && head_vld;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      occ    <= 2'd0;
      for (int i = 0; i < FETCH_DEPTH; i++) mem[i] <= '0;
`ifdef FETCH_PREDECODE_EN
      ctrl_mem <= '0;
`endif
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
`ifdef FETCH_PREDECODE_EN
        ctrl_mem[wr_ptr] <= push_ctrl;
`endif
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      occ <= occ + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding imem request into a 2-entry buffer; request->instValid is 2 cycles minimum.
// Requests stall while the buffer is full; breakPipe flushes and drops in-flight data. FETCH_PREDECODE_EN adds isCtrl.
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic        pcAdvance,
  input  logic        breakPipe,
  input  logic        stop,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemAck,
  input  logic [31:0] imemData,
  output logic        instValid,
  output logic [31:0] inst,
  output logic [31:0] instPc,
  input  logic        instTaken
`ifdef FETCH_PREDECODE_EN
  ,
  output logic        isCtrl
`endif
);

  fetch_state_t state;
  fetch_entry_t head;
  logic         buf_push;
  logic         buf_full;

  assign buf_push = (state == ST_WAIT) && imemAck && !breakPipe;

  fetch_buffer u_buf (
    .clk      (clk),
    .reset    (reset),
    .flush    (breakPipe),
    .push     (buf_push),
    .push_dat ('{pc: imemAddr, inst: imemData}),
`ifdef FETCH_PREDECODE_EN
    .push_ctrl(is_ctrl_op(imemData)),
    .head_ctrl(isCtrl),
`endif
    .pop      (instTaken && !stop),
    .head_vld (instValid),
    .head_dat (head),
    .full     (buf_full)
  );

  assign inst   = head.inst;
  assign instPc = head.pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      imemReq   <= 1'b0;
      imemAddr  <= 32'd0;
      pcAdvance <= 1'b0;
    end else begin
      pcAdvance <= 1'b0;
      case (state)
        ST_IDLE: begin
          // pc only steps at the end of the pcAdvance cycle, so latching then would refetch the old address.
          if (!breakPipe && !buf_full && !pcAdvance) begin
            imemAddr <= pc;
            imemReq  <= 1'b1;
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imemAck) begin
            imemReq   <= 1'b0;
            pcAdvance <= !breakPipe;
            state     <= ST_IDLE;
          end else if (breakPipe) begin
            state <= ST_DROP;
          end
        end
        ST_DROP: begin
          if (imemAck) begin
            imemReq <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: begin
          imemReq <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a scoreboard of expected {pc, inst} entries.
// A standalone fetch_buffer covers the full push+pop corner, which one outstanding request never reaches.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset, breakPipe, stop, imemAck, instTaken;
  logic [31:0] pc, imemData;
  logic        pcAdvance, imemReq, instValid;
  logic [31:0] imemAddr, inst, instPc;
`ifdef FETCH_PREDECODE_EN
  logic        isCtrl, fb_ctrl;
`endif

  logic         fb_flush, fb_push, fb_pop, fb_vld, fb_full;
  fetch_entry_t fb_dat, fb_head;

  int checks = 0;
  int errors = 0;
  fetch_entry_t sb[$];
  fetch_entry_t fbq[$];

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .reset(reset), .pc(pc), .pcAdvance(pcAdvance), .breakPipe(breakPipe),
    .stop(stop), .imemReq(imemReq), .imemAddr(imemAddr), .imemAck(imemAck),
    .imemData(imemData), .instValid(instValid), .inst(inst), .instPc(instPc),
    .instTaken(instTaken)
`ifdef FETCH_PREDECODE_EN
    , .isCtrl(isCtrl)
`endif
  );

  fetch_buffer u_fb (
    .clk(clk), .reset(reset), .flush(fb_flush), .push(fb_push), .push_dat(fb_dat),
`ifdef FETCH_PREDECODE_EN
    .push_ctrl(1'b0), .head_ctrl(fb_ctrl),
`endif
    .pop(fb_pop), .head_vld(fb_vld), .head_dat(fb_head), .full(fb_full)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic fetch_entry_t mk(input logic [31:0] a, input logic [31:0] d);
    fetch_entry_t e;
    e.pc   = a;
    e.inst = d;
    return e;
  endfunction

  task automatic chk_head(input string tag);
    if (sb.size() == 0) begin
      chk1({tag, "_valid"}, instValid, 1'b0);
    end else begin
      chk1({tag, "_valid"}, instValid, 1'b1);
      chk({tag, "_instPc"}, instPc, sb[0].pc);
      chk({tag, "_inst"}, inst, sb[0].inst);
`ifdef FETCH_PREDECODE_EN
      chk1({tag, "_isCtrl"}, isCtrl, sb[0].inst[6:0] == 7'h6F || sb[0].inst[6:0] == 7'h67 ||
                                     sb[0].inst[6:0] == 7'h63);
`endif
    end
  endtask

  task automatic chk_fb(input string tag);
    if (fbq.size() == 0) begin
      chk1({tag, "_vld"}, fb_vld, 1'b0);
    end else begin
      chk1({tag, "_vld"}, fb_vld, 1'b1);
      chk({tag, "_pc"}, fb_head.pc, fbq[0].pc);
      chk({tag, "_inst"}, fb_head.inst, fbq[0].inst);
    end
  endtask

  task automatic wait_req(input string tag, input logic [31:0] exp_addr);
    int n = 0;
    while (imemReq !== 1'b1 && n < 16) begin
      step();
      n++;
    end
    chk1({tag, "_req_seen"}, imemReq, 1'b1);
    chk({tag, "_addr"}, imemAddr, exp_addr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; pc = 32'h0; breakPipe = 1'b0; stop = 1'b0; imemAck = 1'b0;
    imemData = 32'h0; instTaken = 1'b0;
    fb_flush = 1'b0; fb_push = 1'b0; fb_pop = 1'b0; fb_dat = '0;
    step(); step();
    chk1("rst_req", imemReq, 1'b0);
    chk("rst_addr", imemAddr, 32'h0);
    chk1("rst_adv", pcAdvance, 1'b0);
    chk1("rst_valid", instValid, 1'b0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_instPc", instPc, 32'h0);

    // Basic fetch: request, ack one cycle later, head visible two cycles after request.
    reset = 1'b0; pc = 32'h100;
    step();
    chk1("f0_req", imemReq, 1'b1);
    chk("f0_addr", imemAddr, 32'h100);
    chk1("f0_valid_early", instValid, 1'b0);
    step();
    chk1("f0_req_hold", imemReq, 1'b1);
    chk("f0_addr_hold", imemAddr, 32'h100);
    imemAck = 1'b1; imemData = 32'h0000006F; sb.push_back(mk(32'h100, 32'h0000006F));
    step();
    imemAck = 1'b0; imemData = 32'h0;
    chk1("f0_adv", pcAdvance, 1'b1);
    chk1("f0_req_drop", imemReq, 1'b0);
    chk_head("f0");
    pc = 32'h104; stop = 1'b1; instTaken = 1'b1;
    step();
    chk1("f0_adv_once", pcAdvance, 1'b0);

    // Stall with instTaken held: buffer fills to two and requests stop.
    wait_req("f1", 32'h104);
    imemAck = 1'b1; imemData = 32'h00000013; sb.push_back(mk(32'h104, 32'h00000013));
    step();
    imemAck = 1'b0;
    chk1("f1_adv", pcAdvance, 1'b1);
    pc = 32'h108;
    for (int i = 0; i < 3; i++) begin
      chk1("stall_req", imemReq, 1'b0);
      chk("stall_occ", 32'(dut.u_buf.occ), 32'd2);
      chk_head("stall");
      step();
    end
    stop = 1'b0;
    void'(sb.pop_front());
    step();
    instTaken = 1'b0;
    chk_head("release");
    wait_req("f2", 32'h108);

    // Flush while waiting; ack arrives three cycles after breakPipe and is dropped.
    breakPipe = 1'b1; pc = 32'h200; sb.delete();
    step();
    breakPipe = 1'b0;
    chk("drop_state", 32'(dut.state), 32'(ST_DROP));
    chk1("drop_req", imemReq, 1'b1);
    chk("drop_addr", imemAddr, 32'h108);
    chk_head("drop_flush");
    step(); step();
    imemAck = 1'b1; imemData = 32'hDEAD0000;
    step();
    imemAck = 1'b0;
    chk1("drop_adv", pcAdvance, 1'b0);
    chk1("drop_req_done", imemReq, 1'b0);
    chk_head("drop_done");
    wait_req("f3", 32'h200);

    // One entry buffered, then breakPipe and ack together.
    imemAck = 1'b1; imemData = 32'h12345678; sb.push_back(mk(32'h200, 32'h12345678));
    step();
    imemAck = 1'b0;
    chk1("f3_adv", pcAdvance, 1'b1);
    chk_head("f3");
    pc = 32'h204;
    wait_req("f4", 32'h204);
    imemAck = 1'b1; imemData = 32'hBADBAD00; breakPipe = 1'b1; pc = 32'h300;
    step();
    imemAck = 1'b0; breakPipe = 1'b0; sb.delete();
    chk_head("brk_ack");
    chk1("brk_ack_adv", pcAdvance, 1'b0);
    chk1("brk_ack_req", imemReq, 1'b0);
    step();
    chk1("brk_ack_adv2", pcAdvance, 1'b0);
    wait_req("f5", 32'h300);

    // Normal consume.
    imemAck = 1'b1; imemData = 32'h00000063; sb.push_back(mk(32'h300, 32'h00000063));
    step();
    imemAck = 1'b0;
    chk1("f5_adv", pcAdvance, 1'b1);
    chk_head("f5");
    pc = 32'h304; instTaken = 1'b1;
    step();
    void'(sb.pop_front());
    instTaken = 1'b0;
    chk_head("f5_pop");
    wait_req("f6", 32'h304);

    // Reset while waiting; a late ack must be ignored.
    reset = 1'b1;
    step();
    chk1("wrst_req", imemReq, 1'b0);
    chk("wrst_addr", imemAddr, 32'h0);
    chk1("wrst_valid", instValid, 1'b0);
    chk("wrst_inst", inst, 32'h0);
    chk("wrst_instPc", instPc, 32'h0);
    reset = 1'b0; pc = 32'h400; imemAck = 1'b1; imemData = 32'hFEEDF00D;
    step();
    imemAck = 1'b0;
    chk1("late_ack_adv", pcAdvance, 1'b0);
    chk1("late_ack_valid", instValid, 1'b0);
    chk1("late_ack_req", imemReq, 1'b1);
    chk("late_ack_addr", imemAddr, 32'h400);

    // Buffer corners: full push+pop, empty pop, flush over push.
    fb_push = 1'b1; fb_dat = mk(32'h100, 32'hA0); fbq.push_back(fb_dat);
    step();
    fb_dat = mk(32'h104, 32'hA4); fbq.push_back(fb_dat);
    step();
    fb_push = 1'b0;
    chk1("fb_full", fb_full, 1'b1);
    chk_fb("fb_two");
    fb_push = 1'b1; fb_pop = 1'b1; fb_dat = mk(32'h108, 32'hA8);
    void'(fbq.pop_front()); fbq.push_back(fb_dat);
    step();
    fb_push = 1'b0;
    chk1("fb_full_pp", fb_full, 1'b1);
    chk_fb("fb_pp");
    step();
    void'(fbq.pop_front());
    chk1("fb_not_full", fb_full, 1'b0);
    chk_fb("fb_pop1");
    step();
    void'(fbq.pop_front());
    chk_fb("fb_empty");
    fb_push = 1'b1; fb_dat = mk(32'h10C, 32'hAC); fbq.push_back(fb_dat);
    step();
    fb_push = 1'b0; fb_pop = 1'b0;
    chk_fb("fb_pop_empty_push");
    fb_flush = 1'b1; fb_push = 1'b1; fb_dat = mk(32'h110, 32'hB0);
    step();
    fb_flush = 1'b0; fb_push = 1'b0; fbq.delete();
    chk_fb("fb_flush");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port pc, input, 32 bits: next fetch address from the PC manager.
REQ-004 SHALL have port pcAdvance, output, 1 bit: one-cycle pulse; the PC manager may step to the next address.
REQ-005 SHALL have port breakPipe, input, 1 bit: flush request from the PC manager on a taken jump or branch.
REQ-006 SHALL have port stop, input, 1 bit: pipeline stall; decode must not consume.
REQ-007 SHALL have port imemReq, output, 1 bit: instruction-memory request.
REQ-008 SHALL have port imemAddr, output, 32 bits: request address.
REQ-009 SHALL have port imemAck, input, 1 bit: memory returns data this cycle.
REQ-010 SHALL have port imemData, input, 32 bits: instruction word, valid when imemAck=1.
REQ-011 SHALL have port instValid, output, 1 bit: the buffer head is presented to decode.
REQ-012 SHALL have port inst, output, 32 bits: head instruction.
REQ-013 SHALL have port instPc, output, 32 bits: address of the head instruction.
REQ-014 SHALL have port instTaken, input, 1 bit: decode consumes the head this cycle.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT and DROP.
REQ-016 IDLE: when buffer occupancy < 2, breakPipe=0 and reset=0, SHALL latch pc into imemAddr, assert imemReq and go to WAIT next cycle.
REQ-017 WAIT: SHALL hold imemReq=1 and imemAddr stable until imemAck=1.
REQ-018 WAIT with imemAck=1 and breakPipe=0: SHALL push {imemAddr, imemData}, pulse pcAdvance for exactly one cycle, deassert imemReq and return to IDLE.
REQ-019 WAIT with breakPipe=1 and imemAck=0: SHALL go to DROP; DROP SHALL keep imemReq=1 until imemAck, discard the data, then return to IDLE with no pcAdvance.
REQ-020 WAIT with breakPipe=1 and imemAck=1 in the same cycle: SHALL discard the data, give no pcAdvance, and return to IDLE.
REQ-021 The buffer SHALL be a 2-entry FIFO of {pc, inst}.
REQ-022 instValid SHALL equal (occupancy ≠ 0).
REQ-023 A pop SHALL occur only when instValid=1, instTaken=1 and stop=0; instTaken SHALL be ignored while stop=1.
REQ-024 Push and pop in the same cycle SHALL be allowed at any occupancy, including full; occupancy stays unchanged.
REQ-025 breakPipe=1 SHALL empty the FIFO next cycle, override any same-cycle push or pop, and force instValid=0 the next cycle.
REQ-026 Minimum latency: request in cycle N, imemAck in N+1, instValid=1 in N+2.
REQ-027 Pointer and occupancy arithmetic SHALL wrap modulo 2 with no overflow or underflow.

Reset
REQ-028 reset=1 SHALL force state IDLE, occupancy 0, imemReq=0, imemAddr=0, pcAdvance=0, instValid=0, inst=0 and instPc=0, overriding all other inputs.
REQ-029 reset asserted in WAIT SHALL abandon the request; an imemAck arriving after reset SHALL be ignored.

Configuration
REQ-030 With macro FETCH_PREDECODE_EN defined, SHALL add output isCtrl, 1 bit, meaning the head instruction's opcode[6:0] is 1101111, 1100111 or 1100011; isCtrl SHALL be stored per FIFO entry at push time and reset to 0.
REQ-031 Without FETCH_PREDECODE_EN, port isCtrl and its storage SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-032 The shared pipeline package SHALL hold the FSM state encoding, the FIFO depth constant (2) and the three control-opcode constants.
REQ-033 The FIFO SHALL be a sub-module named fetch_buffer; the FSM and handshake logic SHALL be in fetch_stage.

Verification
REQ-034 Reset then pc=0x100 with imemAck one cycle after imemReq -> imemAddr=0x100, one pcAdvance pulse, instValid=1 with instPc=0x100 and inst=imemData two cycles after the request.
REQ-035 stop=1 with instTaken=1 and two fetches completed -> occupancy 2, imemReq stays 0, instValid stays 1; release stop -> head pops and a new request issues.
REQ-036 breakPipe in WAIT with imemAck three cycles later -> state DROP, data discarded, no pcAdvance, FIFO empty, next request uses the new pc.
REQ-037 breakPipe and imemAck in the same cycle with one entry buffered -> FIFO empty next cycle, instValid=0, no pcAdvance.
REQ-038 Full FIFO with instTaken=1, stop=0 and imemAck in the same cycle -> occupancy stays 2 and order is preserved (0x104 then 0x108).
REQ-039 With FETCH_PREDECODE_EN defined, fetching 0x0000006F -> isCtrl=1; fetching 0x00000013 -> isCtrl=0.
